// File: rtl/aes_gcm_pkg.sv
// Shared types and GF(2^128) helpers for the AES-GCM GHASH stage.
// Vectors are [0:127]: index 0 holds the x^0 coefficient, as in GCM.
package aes_gcm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL_A,
      ST_MUL_C,
      ST_WAIT_CT,
      ST_MUL_L,
      ST_DONE
   } ghash_state_t;

   localparam logic [0:127] GCM_R = 128'hE1 << 120;

   typedef struct packed {
      logic [0:127] z;
      logic [0:127] v;
   } gf_zv_t;

   // Applies the first n bits of h_digit (index 0 first) to the running Z/V pair.
   function automatic gf_zv_t fn_gf128_mul_digit(input logic [0:127] z, input logic [0:127] v,
                                                 input logic [0:31] h_digit, input int n);
      gf_zv_t acc;
      acc.z = z;
      acc.v = v;
      for (int i = 0; i < 32; i++) begin
         if (i < n) begin
            if (h_digit[i]) acc.z = acc.z ^ acc.v;
            acc.v = acc.v[127] ? ((acc.v >> 1) ^ GCM_R) : (acc.v >> 1);
         end
      end
      return acc;
   endfunction

   // Zeroes bits [r:127] of the final ciphertext block when it is partial.
   function automatic logic [0:127] fn_ct_mask(input logic [0:127] ct, input logic [6:0] r,
                                               input logic last);
      logic [0:127] keep;
      keep = ~({128{1'b1}} >> r);
      if (!last || r == 7'd0) keep = '1;
      return ct & keep;
   endfunction

endpackage

// File: rtl/aes_gf128_mul_serial.sv
// Digit-serial GF(2^128) multiplier: Z = X * H in 128/MUL_DIGIT cycles.
// o_z is the combinational result during the o_done cycle so a new start can chain on it.
module aes_gf128_mul_serial
   import aes_gcm_pkg::*;
#(
   parameter int MUL_DIGIT = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_start,
   input  logic [0:127] i_x,
   input  logic [0:127] i_h,
   output logic         o_done,
   output logic [0:127] o_z
);
   localparam int M  = 128 / MUL_DIGIT;
   localparam int CW = (M > 1) ? $clog2(M) : 1;
   localparam logic [CW-1:0] LAST = CW'(M - 1);

   logic [0:127]  r_z;
   logic [0:127]  r_v;
   logic [0:127]  r_h;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   gf_zv_t        w_step;

   assign w_step = fn_gf128_mul_digit(r_z, r_v, r_h[0:31], MUL_DIGIT);
   assign o_done = r_busy && (r_cnt == LAST);
   assign o_z    = w_step.z;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_z    <= '0;
         r_v    <= '0;
         r_h    <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_z    <= '0;
         r_v    <= i_x;
         r_h    <= i_h;
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_z   <= w_step.z;
         r_v   <= w_step.v;
         r_h   <= r_h << MUL_DIGIT;
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == LAST) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/aes_gcm_ghash_stage.sv
// GHASH accumulation and tag generation for AES-GCM with a valid/ready input.
// Optional macro AES_GHASH_CT_PASSTHRU_EN adds a registered masked-ciphertext output.
module aes_gcm_ghash_stage
   import aes_gcm_pkg::*;
#(
   parameter int MUL_DIGIT = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic         i_new_instance,
   input  logic [0:127] i_cipher_text,
   input  logic [0:127] i_aad,
   input  logic [0:127] i_h,
   input  logic [0:127] i_encrypted_j0,
   input  logic [0:127] i_instance_size,
   output logic [0:127] o_tag,
   output logic         o_tag_valid,
   output logic         o_error
`ifdef AES_GHASH_CT_PASSTHRU_EN
   ,
   output logic [0:127] o_cipher_text,
   output logic         o_ct_valid
`endif
);
   ghash_state_t r_state;
   logic [0:127] r_x;
   logic [0:127] r_hkey;
   logic [0:127] r_ej0;
   logic [0:127] r_size;
   logic [0:127] r_ct;
   logic [56:0]  r_nblk;
   logic [0:127] r_tag;
   logic         r_tag_valid;
   logic         r_error;

   logic         w_accept;
   logic         w_new_start;
   logic         w_wait_start;
   logic [63:0]  w_new_lena;
   logic [63:0]  w_new_lenc;
   logic [56:0]  w_new_nblk;
   logic         w_new_illegal;
   logic [0:127] w_new_ct;
   logic [0:127] w_wait_ct;
   logic         w_start;
   logic [0:127] w_operand;
   logic [0:127] w_mul_h;
   logic         w_mul_done;
   logic [0:127] w_mul_z;

   assign o_ready      = (r_state == ST_IDLE) | (r_state == ST_WAIT_CT);
   assign w_accept     = i_valid & o_ready;
   assign w_new_lena   = i_instance_size[0:63];
   assign w_new_lenc   = i_instance_size[64:127];
   assign w_new_nblk   = w_new_lenc[63:7] + 57'(|w_new_lenc[6:0]);
   assign w_new_illegal = (w_new_lena > 64'd128);
   assign w_new_start  = w_accept & i_new_instance & ~w_new_illegal;
   assign w_wait_start = w_accept & ~i_new_instance & (r_state == ST_WAIT_CT);
   assign w_new_ct     = fn_ct_mask(i_cipher_text, w_new_lenc[6:0], w_new_nblk == 57'd1);
   assign w_wait_ct    = fn_ct_mask(i_cipher_text, r_size[121:127], r_nblk == 57'd1);

   assign o_tag       = r_tag;
   assign o_tag_valid = r_tag_valid;
   assign o_error     = r_error;

   // Operand selection: the next multiply starts on the same edge the previous one completes.
   always_comb begin
      w_start   = 1'b0;
      w_operand = '0;
      w_mul_h   = r_hkey;
      if (w_new_start) begin
         w_start = 1'b1;
         w_mul_h = i_h;
         if (w_new_lena != 64'd0)      w_operand = i_aad;
         else if (w_new_nblk != 57'd0) w_operand = w_new_ct;
         else                          w_operand = i_instance_size;
      end else if (w_wait_start) begin
         w_start   = 1'b1;
         w_operand = r_x ^ w_wait_ct;
      end else if (w_mul_done) begin
         case (r_state)
            ST_MUL_A: begin
               w_start   = 1'b1;
               w_operand = w_mul_z ^ ((r_nblk != 57'd0) ? r_ct : r_size);
            end
            ST_MUL_C: begin
               if (r_nblk == 57'd1) begin
                  w_start   = 1'b1;
                  w_operand = w_mul_z ^ r_size;
               end
            end
            default: ;
         endcase
      end
   end

   aes_gf128_mul_serial #(
      .MUL_DIGIT (MUL_DIGIT)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_start),
      .i_x     (w_operand),
      .i_h     (w_mul_h),
      .o_done  (w_mul_done),
      .o_z     (w_mul_z)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_x         <= '0;
         r_hkey      <= '0;
         r_ej0       <= '0;
         r_size      <= '0;
         r_ct        <= '0;
         r_nblk      <= '0;
         r_tag       <= '0;
         r_tag_valid <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_tag_valid <= 1'b0;
         r_error     <= 1'b0;
         case (r_state)
            ST_IDLE, ST_WAIT_CT: begin
               if (w_accept) begin
                  if (i_new_instance) begin
                     // A new instance arriving in WAIT_CT aborts the open one.
                     r_error <= w_new_illegal | (r_state == ST_WAIT_CT);
                     if (w_new_illegal) begin
                        r_state <= ST_IDLE;
                     end else begin
                        r_x    <= '0;
                        r_hkey <= i_h;
                        r_ej0  <= i_encrypted_j0;
                        r_size <= i_instance_size;
                        r_ct   <= w_new_ct;
                        r_nblk <= w_new_nblk;
                        if (w_new_lena != 64'd0)      r_state <= ST_MUL_A;
                        else if (w_new_nblk != 57'd0) r_state <= ST_MUL_C;
                        else                          r_state <= ST_MUL_L;
                     end
                  end else if (r_state == ST_IDLE) begin
                     r_error <= 1'b1;
                  end else begin
                     r_state <= ST_MUL_C;
                  end
               end
            end
            ST_MUL_A: begin
               if (w_mul_done) begin
                  r_x     <= w_mul_z;
                  r_state <= (r_nblk != 57'd0) ? ST_MUL_C : ST_MUL_L;
               end
            end
            ST_MUL_C: begin
               if (w_mul_done) begin
                  r_x     <= w_mul_z;
                  r_nblk  <= r_nblk - 57'd1;
                  r_state <= (r_nblk == 57'd1) ? ST_MUL_L : ST_WAIT_CT;
               end
            end
            ST_MUL_L: begin
               if (w_mul_done) begin
                  r_tag       <= w_mul_z ^ r_ej0;
                  r_tag_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE:  r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef AES_GHASH_CT_PASSTHRU_EN
   logic [0:127] r_ct_out;
   logic         r_ct_valid;

   assign o_cipher_text = r_ct_out;
   assign o_ct_valid    = r_ct_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ct_out   <= '0;
         r_ct_valid <= 1'b0;
      end else begin
         r_ct_valid <= 1'b0;
         if (w_new_start && (w_new_nblk != 57'd0)) begin
            r_ct_out   <= w_new_ct;
            r_ct_valid <= 1'b1;
         end else if (w_wait_start) begin
            r_ct_out   <= w_wait_ct;
            r_ct_valid <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_aes_gcm_ghash_stage.sv
// Scoreboard bench for aes_gcm_ghash_stage: NIST GCM vectors plus a bitwise reference multiply.
// Override MUL_DIGIT (1, 8, 32) to sweep multiplier width; expected latencies scale with M.
module tb_aes_gcm_ghash_stage;
   parameter int MUL_DIGIT = 8;
   localparam int M = 128 / MUL_DIGIT;

   localparam logic [0:127] GR     = 128'hE1 << 120;
   localparam logic [0:127] H      = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [0:127] EJ0    = 128'h58e2fccefa7e3061367f1d57a4e7455a;
   localparam logic [0:127] C_TC2  = 128'h0388dace60b6a392f328c2b971b2fe78;
   localparam logic [0:127] T_TC2  = 128'hab6e47d42cec13bdf53a67b21257bddf;
   localparam logic [0:127] SZ_TC2 = 128'h00000000000000000000000000000080;
   localparam logic [0:127] H2     = 128'hb83b533708bf535d0aa6e52980d53b78;
   localparam logic [0:127] EJ2    = 128'h3247184b3c4f69a44dbcd22887bbb418;
   localparam logic [0:127] C1     = 128'h42831ec2217774244b7221b784d0d49c;
   localparam logic [0:127] C2     = 128'he3aa212f2c02a4e035c17e2329aca12e;
   localparam logic [0:127] MASK72 = 128'hFFFFFFFFFFFFFFFFFF00000000000000;
   localparam logic [0:127] AAD64  = 128'hfeedfacedeadbeef0000000000000000;
   localparam logic [0:127] AAD128 = 128'hfeedfacedeadbeeffeedfacedeadbeef;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_valid;
   logic         o_ready;
   logic         i_new_instance;
   logic [0:127] i_cipher_text;
   logic [0:127] i_aad;
   logic [0:127] i_h;
   logic [0:127] i_encrypted_j0;
   logic [0:127] i_instance_size;
   logic [0:127] o_tag;
   logic         o_tag_valid;
   logic         o_error;
`ifdef AES_GHASH_CT_PASSTHRU_EN
   logic [0:127] o_cipher_text;
   logic         o_ct_valid;
`endif

   aes_gcm_ghash_stage #(
      .MUL_DIGIT (MUL_DIGIT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_valid         (i_valid),
      .o_ready         (o_ready),
      .i_new_instance  (i_new_instance),
      .i_cipher_text   (i_cipher_text),
      .i_aad           (i_aad),
      .i_h             (i_h),
      .i_encrypted_j0  (i_encrypted_j0),
      .i_instance_size (i_instance_size),
      .o_tag           (o_tag),
      .o_tag_valid     (o_tag_valid),
      .o_error         (o_error)
`ifdef AES_GHASH_CT_PASSTHRU_EN
      ,
      .o_cipher_text   (o_cipher_text),
      .o_ct_valid      (o_ct_valid)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int next_id = 0;

   typedef struct {
      logic         is_err;
      logic [0:127] tag;
      int           due;
      int           id;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   // Textbook bit-at-a-time GCM product.
   function automatic logic [0:127] ref_mul(input logic [0:127] x, input logic [0:127] y);
      logic [0:127] z;
      logic [0:127] v;
      z = '0;
      v = y;
      for (int i = 0; i < 128; i++) begin
         if (x[i]) z = z ^ v;
         v = v[127] ? ((v >> 1) ^ GR) : (v >> 1);
      end
      return z;
   endfunction

   task automatic push_exp(input logic is_err, input logic [0:127] tag, input int due);
      exp_t e;
      e.is_err = is_err;
      e.tag    = tag;
      e.due    = due;
      e.id     = next_id;
      next_id++;
      sb.push_back(e);
   endtask

   task automatic check1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0b, required %0b", name, act, req);
      end else begin
         $display("check %s ok (%0b)", name, act);
      end
   endtask

   task automatic check128(input string name, input logic [0:127] act, input logic [0:127] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end else begin
         $display("check %s ok (%h)", name, act);
      end
   endtask

   task automatic send_beat(input logic nw, input logic [0:127] aad, input logic [0:127] ct,
                            input logic [0:127] h, input logic [0:127] ej0,
                            input logic [0:127] size, output int acc);
      int waited;
      waited = 0;
      @(negedge clk);
      i_valid         = 1'b1;
      i_new_instance  = nw;
      i_aad           = aad;
      i_cipher_text   = ct;
      i_h             = h;
      i_encrypted_j0  = ej0;
      i_instance_size = size;
      while (!o_ready && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      if (!o_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: o_ready=%0b after %0d cycles, required 1", o_ready, waited);
      end
      @(posedge clk);
      #1;
      acc = cyc;
      i_valid = 1'b0;
   endtask

   // Monitor: every tag or error pulse must match the head of the scoreboard, on time.
   always @(negedge clk) begin
      if (!rst && (o_tag_valid || o_error)) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: tag_valid=%0b error=%0b tag=%h at cycle %0d, required none",
                     o_tag_valid, o_error, o_tag, cyc);
         end else begin
            mon_e = sb.pop_front();
            if ((o_error !== mon_e.is_err) || (o_tag_valid === mon_e.is_err) ||
                (!mon_e.is_err && o_tag !== mon_e.tag) || (cyc != mon_e.due)) begin
               errors++;
               $display("FAIL txn%0d: got error=%0b tag=%h cycle=%0d, required error=%0b tag=%h cycle=%0d",
                        mon_e.id, o_error, o_tag, cyc, mon_e.is_err, mon_e.tag, mon_e.due);
            end else begin
               $display("txn%0d ok: error=%0b tag=%h cycle=%0d", mon_e.id, o_error, o_tag, cyc);
            end
         end
      end
   end

   logic [0:127] x;
   logic [0:127] sz;
   int acc;

   initial begin
      rst = 1'b1;
      i_valid = 1'b0;
      i_new_instance = 1'b0;
      i_cipher_text = '0;
      i_aad = '0;
      i_h = '0;
      i_encrypted_j0 = '0;
      i_instance_size = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check1("reset_ready", o_ready, 1'b1);
      check1("reset_tag_valid", o_tag_valid, 1'b0);
      check1("reset_error", o_error, 1'b0);
      check128("reset_tag", o_tag, '0);

      // TC1: empty message, tag equals E(J0)
      send_beat(1'b1, '0, '0, H, EJ0, '0, acc);
      push_exp(1'b0, EJ0, acc + M);

      // TC2: one full ciphertext block
      send_beat(1'b1, '0, C_TC2, H, EJ0, SZ_TC2, acc);
      push_exp(1'b0, T_TC2, acc + 2 * M);

      // Continuation beat with nothing open
      send_beat(1'b0, '0, C1, H, EJ0, SZ_TC2, acc);
      push_exp(1'b1, '0, acc);

      // lenA = 256 is rejected
      send_beat(1'b1, AAD128, C1, H, EJ0, {64'd256, 64'd128}, acc);
      push_exp(1'b1, '0, acc);

      // AAD of 64 bits plus one ciphertext block, different H
      sz = {64'd64, 64'd128};
      send_beat(1'b1, AAD64, C1, H2, EJ2, sz, acc);
      x = ref_mul(AAD64, H2);
      x = ref_mul(x ^ C1, H2);
      x = ref_mul(x ^ sz, H2);
      push_exp(1'b0, x ^ EJ2, acc + 3 * M);

      // lenC = 200: second block keeps only bits [0:71]
      sz = {64'd0, 64'd200};
      send_beat(1'b1, '0, C1, H, EJ0, sz, acc);
      send_beat(1'b0, '0, C2, H, EJ0, sz, acc);
      x = ref_mul(C1, H);
      x = ref_mul(x ^ (C2 & MASK72), H);
      x = ref_mul(x ^ sz, H);
      push_exp(1'b0, x ^ EJ0, acc + 2 * M);

      // Abort: new instance while waiting for the second block
      send_beat(1'b1, '0, C2, H2, EJ2, {64'd0, 64'd256}, acc);
      send_beat(1'b1, '0, C_TC2, H, EJ0, SZ_TC2, acc);
      push_exp(1'b1, '0, acc);
      push_exp(1'b0, T_TC2, acc + 2 * M);

      // Reset in the middle of MUL_C
      send_beat(1'b1, '0, C1, H2, EJ2, SZ_TC2, acc);
      repeat (M / 2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check1("midreset_ready", o_ready, 1'b1);
      check1("midreset_tag_valid", o_tag_valid, 1'b0);
      check1("midreset_error", o_error, 1'b0);
      check128("midreset_tag", o_tag, '0);

      send_beat(1'b1, '0, C_TC2, H, EJ0, SZ_TC2, acc);
      push_exp(1'b0, T_TC2, acc + 2 * M);

      // AAD-only instance, lenA = 128
      sz = {64'd128, 64'd0};
      send_beat(1'b1, AAD128, C2, H2, EJ2, sz, acc);
      x = ref_mul(AAD128, H2);
      x = ref_mul(x ^ sz, H2);
      push_exp(1'b0, x ^ EJ2, acc + 2 * M);

      for (int i = 0; i < 5000 && sb.size() != 0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d outputs outstanding, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
